// File: rtl/riscv_pkg.sv
// RV32I shared decode constants: opcodes, ALU operation classes, bubble instruction.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    ctrl_t       ctrl;
  } idex_t;

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file: 2 combinational read ports with write-back bypass, 1 write port, x0 hardwired.
// Latency: reads are combinational; writes land at the clock edge.
// Backpressure: none, a write presented is always accepted.
module id_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rs1_dat,
  output logic [31:0] rs2_dat
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Next register contents: a write to x0 is dropped.
  always_comb begin
    regs_d = regs_q;
    if (we && wr_addr != 5'd0) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: x0 is constant zero, otherwise same-cycle write data wins.
  always_comb begin
    rs1_dat = regs_q[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_dat = '0;
    end else if (we && wr_addr == rs1_addr) begin
      rs1_dat = wr_data;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rs2_dat = regs_q[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_dat = '0;
    end else if (we && wr_addr == rs2_addr) begin
      rs2_dat = wr_data;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: control decode, immediate generation, operand read, ID/EX register.
// Latency: 1 cycle from IF_PC/IF_instr to ID_*; stall is combinational in the same cycle.
// Backpressure: with ID_HAZARD_EN defined, a load-use pair raises stall for one cycle and a bubble is issued.
module id_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_instr,
  input  logic        flush,
  input  logic        WB_we,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_data,
  output logic        stall,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_rs1_data,
  output logic [31:0] ID_rs2_data,
  output logic [4:0]  ID_rs1,
  output logic [4:0]  ID_rs2,
  output logic [4:0]  ID_rd,
  output logic [31:0] ID_imm,
  output logic [2:0]  ID_funct3,
  output logic [6:0]  ID_funct7,
  output logic        ID_reg_write,
  output logic        ID_mem_read,
  output logic        ID_mem_write,
  output logic        ID_mem_to_reg,
  output logic        ID_alu_src,
  output logic        ID_branch,
  output logic        ID_jump,
  output logic [1:0]  ID_alu_op
);

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  ctrl_t       ctrl;
  logic [31:0] imm;
  logic [31:0] rs1_dat;
  logic [31:0] rs2_dat;
  logic        hazard;
  logic        bubble;
  idex_t       idex_d;
  idex_t       idex_q;

  assign opcode = IF_instr[6:0];
  assign rs1    = IF_instr[19:15];
  assign rs2    = IF_instr[24:20];

  id_regfile u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .we       (WB_we),
    .wr_addr  (WB_rd),
    .wr_data  (WB_data),
    .rs1_dat  (rs1_dat),
    .rs2_dat  (rs2_dat)
  );

  // Control and immediate decode; unknown opcodes decode to an all-zero bubble.
  always_comb begin
    ctrl = '0;
    imm  = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_R;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_I;
        imm            = {{20{IF_instr[31]}}, IF_instr[31:20]};
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        imm             = {{20{IF_instr[31]}}, IF_instr[31:20]};
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {{20{IF_instr[31]}}, IF_instr[31:25], IF_instr[11:7]};
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_BR;
        imm         = {{19{IF_instr[31]}}, IF_instr[31], IF_instr[7],
                       IF_instr[30:25], IF_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {{11{IF_instr[31]}}, IF_instr[31], IF_instr[19:12],
                          IF_instr[20], IF_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {{20{IF_instr[31]}}, IF_instr[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = {IF_instr[31:12], 12'h000};
      end
      default: begin
        ctrl = '0;
        imm  = '0;
      end
    endcase
  end

`ifdef ID_HAZARD_EN
  logic uses_rs1;
  logic uses_rs2;

  // Which source fields the decoded instruction actually reads.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        uses_rs1 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // Load in EX whose destination feeds this instruction: data not ready yet.
  always_comb begin
    hazard = idex_q.ctrl.mem_read && (idex_q.rd != 5'd0) &&
             ((uses_rs1 && idex_q.rd == rs1) || (uses_rs2 && idex_q.rd == rs2));
  end
`else
  // Software schedules around load-use, so hazards are never raised.
  always_comb begin
    hazard = 1'b0;
  end
`endif

  // A redirect already discards this instruction, so there is nothing to hold.
  assign stall  = hazard && !flush;
  assign bubble = flush || hazard;

  // ID/EX next value: a bubble keeps only the PC and carries the NOP encoding.
  always_comb begin
    idex_d       = '0;
    idex_d.pc    = IF_PC;
    idex_d.instr = NOP_INSTR;
    if (!bubble) begin
      idex_d.instr    = IF_instr;
      idex_d.rs1_data = rs1_dat;
      idex_d.rs2_data = rs2_dat;
      idex_d.rs1      = rs1;
      idex_d.rs2      = rs2;
      idex_d.rd       = IF_instr[11:7];
      idex_d.imm      = imm;
      idex_d.funct3   = IF_instr[14:12];
      idex_d.funct7   = IF_instr[31:25];
      idex_d.ctrl     = ctrl;
    end
  end

  // ID/EX pipeline register; reset clears it fully, including the instruction word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ID_PC         = idex_q.pc;
  assign ID_instr      = idex_q.instr;
  assign ID_rs1_data   = idex_q.rs1_data;
  assign ID_rs2_data   = idex_q.rs2_data;
  assign ID_rs1        = idex_q.rs1;
  assign ID_rs2        = idex_q.rs2;
  assign ID_rd         = idex_q.rd;
  assign ID_imm        = idex_q.imm;
  assign ID_funct3     = idex_q.funct3;
  assign ID_funct7     = idex_q.funct7;
  assign ID_reg_write  = idex_q.ctrl.reg_write;
  assign ID_mem_read   = idex_q.ctrl.mem_read;
  assign ID_mem_write  = idex_q.ctrl.mem_write;
  assign ID_mem_to_reg = idex_q.ctrl.mem_to_reg;
  assign ID_alu_src    = idex_q.ctrl.alu_src;
  assign ID_branch     = idex_q.ctrl.branch;
  assign ID_jump       = idex_q.ctrl.jump;
  assign ID_alu_op     = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Randomized self-checking bench for id_stage against a behavioural reference model.
// Latency: model predicts stall in-cycle and the ID/EX contents one edge later.
// Backpressure: the bench re-presents the fetched pair whenever the model predicts a stall.
module tb_id_stage;

`ifdef ID_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] IF_PC;
  logic [31:0] IF_instr;
  logic        flush;
  logic        WB_we;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data;
  logic        stall;
  logic [31:0] ID_PC, ID_instr, ID_rs1_data, ID_rs2_data, ID_imm;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic [2:0]  ID_funct3;
  logic [6:0]  ID_funct7;
  logic        ID_reg_write, ID_mem_read, ID_mem_write, ID_mem_to_reg;
  logic        ID_alu_src, ID_branch, ID_jump;
  logic [1:0]  ID_alu_op;

  id_stage dut (
    .clk           (clk),
    .reset         (reset),
    .IF_PC         (IF_PC),
    .IF_instr      (IF_instr),
    .flush         (flush),
    .WB_we         (WB_we),
    .WB_rd         (WB_rd),
    .WB_data       (WB_data),
    .stall         (stall),
    .ID_PC         (ID_PC),
    .ID_instr      (ID_instr),
    .ID_rs1_data   (ID_rs1_data),
    .ID_rs2_data   (ID_rs2_data),
    .ID_rs1        (ID_rs1),
    .ID_rs2        (ID_rs2),
    .ID_rd         (ID_rd),
    .ID_imm        (ID_imm),
    .ID_funct3     (ID_funct3),
    .ID_funct7     (ID_funct7),
    .ID_reg_write  (ID_reg_write),
    .ID_mem_read   (ID_mem_read),
    .ID_mem_write  (ID_mem_write),
    .ID_mem_to_reg (ID_mem_to_reg),
    .ID_alu_src    (ID_alu_src),
    .ID_branch     (ID_branch),
    .ID_jump       (ID_jump),
    .ID_alu_op     (ID_alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected ID/EX contents. ctl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op}.
  typedef struct {
    bit          bubble;
    bit          known;
    logic [31:0] pc, instr, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [8:0]  ctl;
  } exp_s;

  exp_s        cur;
  logic [31:0] mregs [32];
  bit          last_stall;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Instruction class table: control word, and which sources are read.
  function automatic logic [8:0] ref_ctl(input logic [6:0] op);
    case (op)
      7'b0110011: return 9'b1_0_0_0_0_0_0_10; // R
      7'b0010011: return 9'b1_0_0_0_1_0_0_11; // I-ALU
      7'b0000011: return 9'b1_1_0_1_1_0_0_00; // load
      7'b0100011: return 9'b0_0_1_0_1_0_0_00; // store
      7'b1100011: return 9'b0_0_0_0_0_1_0_01; // branch
      7'b1101111: return 9'b1_0_0_0_1_0_1_00; // jal
      7'b1100111: return 9'b1_0_0_0_1_0_1_00; // jalr
      7'b0110111: return 9'b1_0_0_0_1_0_0_00; // lui
      7'b0010111: return 9'b1_0_0_0_1_0_0_00; // auipc
      default:    return 9'b0;
    endcase
  endfunction

  function automatic bit is_known(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
           (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b1101111) ||
           (op == 7'b1100111) || (op == 7'b0110111) || (op == 7'b0010111);
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
           (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b1100111);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
  endfunction

  // Immediate by arithmetic: assemble the unsigned field value, subtract 2^width if the sign bit is set.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        v = int'(i[31:20]);
        if (i[31]) v = v - 4096;
      end
      7'b0100011: begin
        v = int'(i[31:25]) * 32 + int'(i[11:7]);
        if (i[31]) v = v - 4096;
      end
      7'b1100011: begin
        v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (i[31]) v = v - 8192;
      end
      7'b1101111: begin
        v = int'(i[31]) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        if (i[31]) v = v - 2097152;
      end
      7'b0110111, 7'b0010111: v = int'(i & 32'hFFFFF000);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  task automatic check_outputs();
    check_val("ID_instr", ID_instr, cur.instr);
    check_val("ID_rd", {27'd0, ID_rd}, {27'd0, cur.rd});
    check_val("ctl", {23'd0, ID_reg_write, ID_mem_read, ID_mem_write, ID_mem_to_reg,
                      ID_alu_src, ID_branch, ID_jump, ID_alu_op}, {23'd0, cur.ctl});
    if (!cur.bubble) begin
      check_val("ID_PC", ID_PC, cur.pc);
      check_val("ID_rs1", {27'd0, ID_rs1}, {27'd0, cur.rs1});
      check_val("ID_rs2", {27'd0, ID_rs2}, {27'd0, cur.rs2});
      check_val("ID_funct3", {29'd0, ID_funct3}, {29'd0, cur.f3});
      check_val("ID_funct7", {25'd0, ID_funct7}, {25'd0, cur.f7});
      check_val("ID_rs1_data", ID_rs1_data, cur.rs1d);
      check_val("ID_rs2_data", ID_rs2_data, cur.rs2d);
      if (cur.known) check_val("ID_imm", ID_imm, cur.imm);
    end
  endtask

  // One clock: drive at posedge+1, check stall at negedge, check ID/EX at next posedge+1.
  task automatic cycle(input logic [31:0] pc, input logic [31:0] instr, input logic f,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
    bit   exp_stall;
    exp_s nxt;
    IF_PC = pc; IF_instr = instr; flush = f; WB_we = we; WB_rd = wrd; WB_data = wdat;
    exp_stall = HZ && !f && cur.ctl[7] && (cur.rd != 5'd0) &&
                ((reads_rs1(instr[6:0]) && cur.rd == instr[19:15]) ||
                 (reads_rs2(instr[6:0]) && cur.rd == instr[24:20]));
    @(negedge clk);
    check_val("stall", {31'd0, stall}, {31'd0, exp_stall});
    last_stall = exp_stall;
    nxt = '{default: 0};
    nxt.pc = pc;
    if (f || exp_stall) begin
      nxt.bubble = 1'b1;
      nxt.instr  = 32'h00000013;
    end else begin
      nxt.known = is_known(instr[6:0]);
      nxt.instr = instr;
      nxt.rs1   = instr[19:15];
      nxt.rs2   = instr[24:20];
      nxt.rd    = instr[11:7];
      nxt.f3    = instr[14:12];
      nxt.f7    = instr[31:25];
      nxt.ctl   = ref_ctl(instr[6:0]);
      nxt.imm   = ref_imm(instr);
      nxt.rs1d  = rd_reg(instr[19:15], we, wrd, wdat);
      nxt.rs2d  = rd_reg(instr[24:20], we, wrd, wdat);
    end
    @(posedge clk);
    if (we && wrd != 5'd0) mregs[wrd] = wdat;
    cur = nxt;
    #1;
    check_outputs();
  endtask

  // Issue an instruction, re-presenting it while the model says decode is held.
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    cycle(pc, instr, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 3 && last_stall; k++) cycle(pc, instr, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  // Assert reset away from the edge, check the cleared state, release just after an edge.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    cur = '{default: 0};
    for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_imm", ID_imm, 32'd0);
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    last_stall = 1'b0;
  endtask

  logic [6:0]  ops [11];
  logic [31:0] pc, ins;
  int          stall_cnt;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000, 7'b1111111};
    reset = 1'b1; IF_PC = 0; IF_instr = 0; flush = 0; WB_we = 0; WB_rd = 0; WB_data = 0;
    cur = '{default: 0};
    last_stall = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed decodes.
    cycle(32'h0, 32'h00A00093, 0, 0, 0, 0);
    check_val("itype_imm", ID_imm, 32'd10);
    check_val("itype_alu_op", {30'd0, ID_alu_op}, 32'd3);
    cycle(32'h4, 32'hFE208CE3, 0, 0, 0, 0);
    check_val("btype_imm", ID_imm, 32'hFFFFFFF8);
    // x0 ignores writes.
    cycle(32'h8, 32'h00000013, 0, 1, 5'd0, 32'hDEADBEEF);
    cycle(32'hC, 32'h000001B3, 0, 0, 0, 0);
    check_val("x0_read", ID_rs1_data, 32'd0);
    // Bypass: x2 = 20 stored, x1 = 10 written in the decode cycle.
    cycle(32'h10, 32'h00000013, 0, 1, 5'd2, 32'd20);
    cycle(32'h14, 32'h002081B3, 0, 1, 5'd1, 32'd10);
    check_val("bypass_rs1", ID_rs1_data, 32'd10);
    check_val("bypass_rs2", ID_rs2_data, 32'd20);
    // Load-use pair.
    issue(32'h18, 32'h0080A283);
    stall_cnt = 0;
    cycle(32'h1C, 32'h00228333, 0, 0, 0, 0);
    if (last_stall) begin
      stall_cnt++;
      cycle(32'h1C, 32'h00228333, 0, 0, 0, 0);
    end
    check_val("lu_stall_cycles", stall_cnt, HZ ? 32'd1 : 32'd0);
    check_val("lu_add_rs1", {27'd0, ID_rs1}, 32'd5);
    // Flush beats stall.
    issue(32'h20, 32'h0080A283);
    cycle(32'h24, 32'h00228333, 1, 0, 0, 0);
    check_val("flush_instr", ID_instr, 32'h00000013);
    // Reset mid load-use, then every register reads zero.
    issue(32'h28, 32'h0080A283);
    IF_instr = 32'h00228333;
    do_reset();
    for (int r = 1; r < 32; r++) begin
      issue(32'h100 + 32'(r * 4), {7'd0, 5'(r), 5'(r), 3'd0, 5'd3, 7'b0110011});
    end

    // Random traffic.
    pc = 32'h1000;
    ins = 32'h00000013;
    for (int n = 0; n < 600; n++) begin
      logic f;
      if (!last_stall) begin
        pc  = pc + 4;
        ins = $urandom;
        ins[6:0] = (($urandom_range(0, 3) == 0) ? 7'b0000011 : ops[$urandom_range(0, 10)]);
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) ins = 32'd0;
      end
      f = ($urandom_range(0, 9) == 0);
      cycle(pc, ins, f, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      if (n == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I pipeline, directly downstream of the instruction-fetch stage. Each cycle it takes the fetched PC/instruction pair, decodes the control fields, generates the sign-extended immediate, reads two operands from the 32×32 register file it owns, and registers everything into the ID/EX pipeline register. It also accepts the write-back port from the last stage, detects load-use hazards and drives the stall signal back to fetch.

## Interface
- `NOP_INSTR`, default 32'h00000013: bubble value loaded into `ID_instr` on stall or flush.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `IF_PC` in 32: PC of the fetched instruction.
- `IF_instr` in 32: fetched instruction.
- `flush` in 1: branch/jump redirect from EX; squashes the instruction in decode.
- `WB_we`, `WB_rd`, `WB_data` in 1/5/32: register-file write port.
- `stall` out 1: hold PC and the IF register this cycle.
- `ID_PC`, `ID_instr` out 32: registered copies of the PC and instruction.
- `ID_rs1_data`, `ID_rs2_data` out 32: register operands.
- `ID_rs1`, `ID_rs2`, `ID_rd` out 5: register indices.
- `ID_imm` out 32: sign-extended immediate.
- `ID_funct3` out 3, `ID_funct7` out 7: function fields.
- `ID_reg_write`, `ID_mem_read`, `ID_mem_write`, `ID_mem_to_reg`, `ID_alu_src`, `ID_branch`, `ID_jump` out 1: control signals.
- `ID_alu_op` out 2: ALU operation class.

## Operation
- Decode is combinational from `IF_instr`; `ID_*` is registered at `posedge clk`.
- `ID_alu_op` encoding:
  - 00: add (LOAD/STORE/LUI/AUIPC/JAL/JALR)
  - 01: branch compare
  - 10: R-type
  - 11: I-type ALU
- Immediate formats I/S/B/U/J per RV32I, always sign-extended from instr[31]; R-type imm = 0.
- Unknown opcode or all-zero instruction: all control signals = 0 (treated as a bubble).
- `rs1` is used by R/I/LOAD/STORE/BRANCH/JALR; `rs2` is used by R/STORE/BRANCH.
- Register file:
  - x0 reads 0 and ignores writes.
  - Write at `posedge clk` when `WB_we && WB_rd != 0`.
  - Same-cycle write-back bypass: if `WB_we && WB_rd == rsN && rsN != 0`, the read returns `WB_data`.
- Load-use hazard: `stall = ID_mem_read && ID_rd != 0 && ((uses_rs1 && ID_rd == rs1) || (uses_rs2 && ID_rd == rs2))`.
- On stall: the ID/EX register loads a bubble (all control = 0, `ID_instr = NOP_INSTR`, `ID_rd = 0`). The IF pair is re-presented next cycle.
- `flush` has priority over stall: load a bubble and force `stall` to 0.
- Reset (`reset = 0`, any time, including mid-stall):
  - All outputs go to 0 immediately, including `ID_instr = 0` and `stall = 0`.
  - All 32 registers clear to 0.

## Timing
- Latency: 1 cycle from `IF_PC`/`IF_instr` to `ID_*`.
- `stall` is combinational from the ID/EX register and `IF_instr`, valid in the same cycle. It lasts exactly 1 cycle per load-use pair, because the inserted bubble clears `ID_mem_read`.
- A write-back in cycle N is visible to a decode in cycle N (via bypass) and is stored at the end of cycle N.
- Reset release is synchronous to `clk`; the first capture happens at the first rising edge with `reset = 1`.

## Configuration
- `ID_HAZARD_EN` defined: load-use detection and bubble insertion as above.
- `ID_HAZARD_EN` undefined: `stall` is tied to 0 and no hazard bubbles are inserted (software schedules NOPs). The `flush` bubble is unaffected.

## Structure
- Package `riscv_pkg`: opcode constants (OP_R 0110011, OP_IMM 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111, OP_JALR 1100111, OP_LUI 0110111, OP_AUIPC 0010111), `alu_op` encodings and the NOP constant.
- Sub-module `id_regfile`: 2 read ports, 1 write port, x0 hardwiring, bypass and async clear.
- Decode, immediate generation, hazard logic and the ID/EX register live in `id_stage`.

## Test plan
- Reset and x0:
  - Pulse `reset = 0` mid-run → all outputs 0, `stall = 0`, and x1..x31 read 0.
  - Write `WB_rd = 0`, `WB_data = 0xDEADBEEF` → x0 still reads 0.
- I-type decode: `IF_instr = 0x00A00093`, `IF_PC = 0` → next cycle `ID_rd = 1`, `ID_rs1 = 0`, `ID_imm = 10`, `ID_reg_write = 1`, `ID_alu_src = 1`, `ID_alu_op = 11`.
- B-type decode: `IF_instr = 0xFE208CE3` → `ID_imm = 0xFFFFFFF8`, `ID_branch = 1`, `ID_alu_op = 01`, `ID_reg_write = 0`.
- Bypass: with x2 = 20 stored, hold `WB_we = 1`, `WB_rd = 1`, `WB_data = 10` while `IF_instr = 0x002081B3` → `ID_rs1_data = 10`, `ID_rs2_data = 20`.
- Load-use: `0x0080A283` followed by `0x00228333`:
  - With `ID_HAZARD_EN` → `stall = 1` for exactly one cycle, a bubble appears in ID/EX, then the add issues with `ID_rs1 = 5`.
  - Without `ID_HAZARD_EN` → `stall` is never asserted.
- Flush and stall together: force a load-use condition with `flush = 1` → `stall = 0`, ID/EX holds a bubble (`ID_instr = 0x00000013`, all control 0).
